pong_frame_ctrl: RTL and testbench
==================================

// Module: pong_frame_ctrl
// PURPOSE
//  Per-frame game-state sequencer for Pong. Once per frame it updates the paddle and ball positions
//  in a fixed order, then applies wall and paddle bounces and miss detection.
//  - Timing: runs only in vertical blanking, on frame_tick from the VGA sync block.
//  - Outputs: ball_x/ball_y/pad_y feed the pixel generator and stay constant during active video.
// PARAMETERS
//  H_RES     640  visible width (pixels)
//  V_RES     480  visible height (lines)
//  BALL_SIZE 8    ball edge length (pixels)
//  PAD_H     72   paddle height (lines)
//  PAD_X_L   600  paddle left (front) face x
//  WALL_X    32   left wall inner edge x
//  BALL_V    2    ball step per frame, each axis
//  PAD_V     4    paddle step per frame
// PORTS
//  clk       in   1   100 MHz system clock
//  rst_n     in   1   asynchronous reset, active-low
//  frame_tick in  1   1-cycle pulse at the first line of vertical blanking (v_count==480)
//  btn_up    in   1   paddle up, already debounced and synchronised
//  btn_down  in   1   paddle down, already debounced and synchronised
//  ball_x    out  10  ball top-left x
//  ball_y    out  10  ball top-left y
//  pad_y     out  10  paddle top y
//  busy      out  1   high while an update sequence is in progress
//  miss      out  1   1-cycle pulse when the ball passes the paddle
// BEHAVIOUR
//  Reset (async on rst_n=0; any sequence in progress is abandoned, no partial commit):
//  - ball_x=320, ball_y=240, pad_y=204
//  - direction registers: vx=+ (right), vy=+ (down)
//  - busy=0, miss=0, state=IDLE
//  FSM states: IDLE -> PAD -> BALL -> HIT -> IDLE. One cycle per state; busy=1 in PAD, BALL, HIT.
//  - IDLE: a frame_tick moves the FSM to PAD on the next edge. A frame_tick outside IDLE is dropped.
//  - PAD:
//    - btn_up only: pad_y -= PAD_V, clamped at 0.
//    - btn_down only: pad_y += PAD_V, clamped at V_RES-PAD_H (408).
//    - both or neither: pad_y holds.
//  - BALL: each axis steps by BALL_V in its current direction.
//    - vy=- and ball_y<BALL_V: ball_y=0, vy flips to +.
//    - vy=+ and ball_y+BALL_V>V_RES-BALL_SIZE: ball_y=472, vy flips to -.
//    - vx=- and ball_x<WALL_X+BALL_V: ball_x=WALL_X, vx flips to +.
//  - HIT: evaluated on the values committed in BALL and PAD.
//    - Hit condition, all of:
//      - vx=+
//      - ball_x+BALL_SIZE in [PAD_X_L, PAD_X_L+BALL_V-1]
//      - ball_y+BALL_SIZE > pad_y
//      - ball_y < pad_y+PAD_H
//    - On hit: ball_x=PAD_X_L-BALL_SIZE, vx flips to -.
//    - Else if ball_x >= H_RES-BALL_SIZE:
//      - miss=1 for this cycle
//      - ball_x=320, ball_y=240, vx=-; vy keeps its value
//    - Else: no change.
//  Output latency:
//    - pad_y settles 2 edges after the tick edge.
//    - ball_x/ball_y settle 4 edges after it.
//  Arithmetic: all positions unsigned 10-bit. Sums and compares use 11-bit intermediates; no wrap.
//  Simultaneous events:
//    - A vertical bounce and a wall bounce in the same BALL cycle are both applied.
//    - A hit takes priority over a miss.
// STRUCTURE
//  Shared package pong_pkg:
//  - constants H_RES, V_RES, BALL_SIZE, PAD_H
//  - reset positions (320, 240, 204)
//  - state encoding typedef / localparams (IDLE=0, PAD=1, BALL=2, HIT=3)
//  One sub-module: pong_axis_step.
//  - Inputs: pos, dir, step, lo, hi.
//  - Outputs: clamped next position and a flip flag.
//  - Used for ball x, ball y and the paddle; keeps the FSM body free of arithmetic.
// TESTING
//  1. Reset: rst_n=0 mid-BALL state -> all outputs at reset values immediately; no update after release until a tick.
//  2. Free flight: 1 tick from reset, no buttons -> busy high 3 cycles; ball=(322,242); pad_y=204; miss=0.
//  3. Paddle clamp: pad_y=2, btn_up, tick -> pad_y=0; pad_y=406, btn_down, tick -> 408; both pressed -> unchanged.
//  4. Top bounce: ball_y=1, vy=-, tick -> ball_y=0, vy=+; next tick -> ball_y=2.
//  5. Paddle hit: ball_x=590, vx=+, ball_y=pad_y+10, tick -> ball_x=592, vx=-; no miss pulse.
//  6. Miss:
//     - setup: ball_x=630, vx=+, ball_y=pad_y+100
//     - tick -> miss pulse exactly 1 cycle; ball=(320,240); vx=-
//     - a tick during busy is ignored

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants, state encoding and direction type for the Pong frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pong_pkg;

  // Screen and object geometry
  localparam logic [9:0] H_RES     = 10'd640;
  localparam logic [9:0] V_RES     = 10'd480;
  localparam logic [9:0] BALL_SIZE = 10'd8;
  localparam logic [9:0] PAD_H     = 10'd72;
  localparam logic [9:0] PAD_X_L   = 10'd600;
  localparam logic [9:0] WALL_X    = 10'd32;
  localparam logic [9:0] BALL_V    = 10'd2;
  localparam logic [9:0] PAD_V     = 10'd4;

  // Derived limits
  localparam logic [9:0] BALL_X_MISS = H_RES - BALL_SIZE;  // 632
  localparam logic [9:0] BALL_Y_MAX  = V_RES - BALL_SIZE;  // 472
  localparam logic [9:0] PAD_Y_MAX   = V_RES - PAD_H;      // 408

  // Reset positions
  localparam logic [9:0] BALL_X_RST = 10'd320;
  localparam logic [9:0] BALL_Y_RST = 10'd240;
  localparam logic [9:0] PAD_Y_RST  = 10'd204;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PAD  = 2'd1,
    BALL = 2'd2,
    HIT  = 2'd3
  } state_t;

  // POS = right/down, NEG = left/up
  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  function automatic dir_t flip_dir(input dir_t d);
    return (d == DIR_POS) ? DIR_NEG : DIR_POS;
  endfunction

endpackage

// File: rtl/pong_axis_step.sv
// One-axis position step with clamping to [lo, hi]; flags when a clamp reverses direction.
// Latency: purely combinational.
// Backpressure: none.
module pong_axis_step
  import pong_pkg::*;
(
  input  logic [9:0] i_pos,
  input  dir_t       i_dir,
  input  logic [9:0] i_step,
  input  logic [9:0] i_lo,
  input  logic [9:0] i_hi,
  output logic [9:0] o_next,
  output logic       o_flip
);

  // 11-bit intermediates so the compares never wrap
  logic [10:0] w_sum;
  logic [10:0] w_lo_lim;

  assign w_sum    = {1'b0, i_pos} + {1'b0, i_step};
  assign w_lo_lim = {1'b0, i_lo} + {1'b0, i_step};

  // Step in the current direction; clamp to the limit and request a flip when crossing it
  always_comb begin
    o_next = i_pos;
    o_flip = 1'b0;
    if (i_dir == DIR_POS) begin
      if (w_sum > {1'b0, i_hi}) begin
        o_next = i_hi;
        o_flip = 1'b1;
      end else begin
        o_next = w_sum[9:0];
      end
    end else begin
      if ({1'b0, i_pos} < w_lo_lim) begin
        o_next = i_lo;
        o_flip = 1'b1;
      end else begin
        o_next = i_pos - i_step;
      end
    end
  end

endmodule

// File: rtl/pong_frame_ctrl.sv
// Per-frame Pong game-state sequencer: paddle move, ball move, then paddle hit / miss.
// Latency: pad_y commits 2 edges, ball 4 edges after the frame_tick launch edge; busy for 3 cycles.
// Backpressure: none; a frame_tick arriving while busy is dropped.
module pong_frame_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] pad_y,
  output logic       busy,
  output logic       miss
);

  // Ball-front window that counts as touching the paddle face
  localparam logic [10:0] HIT_X_LO  = {1'b0, PAD_X_L};
  localparam logic [10:0] HIT_X_HI  = {1'b0, PAD_X_L} + {1'b0, BALL_V} - 11'd1;
  localparam logic [9:0]  X_NO_CLAMP = 10'h3FF;

  state_t     r_state, w_state_nxt;
  logic [9:0] r_ball_x, r_ball_y, r_pad_y;
  logic [9:0] w_ball_x_nxt, w_ball_y_nxt, w_pad_y_nxt;
  dir_t       r_vx, r_vy, w_vx_nxt, w_vy_nxt;
  logic       w_miss;

  logic [9:0] w_bx_step, w_by_step, w_pad_step;
  logic       w_bx_flip, w_by_flip;
  dir_t       w_pad_dir;
  logic [9:0] w_pad_amt;

  logic [10:0] w_ball_front;
  logic        w_hit;

  // Paddle moves only when exactly one button is held
  assign w_pad_dir = btn_up ? DIR_NEG : DIR_POS;
  assign w_pad_amt = (btn_up ^ btn_down) ? PAD_V : 10'd0;

  pong_axis_step u_step_x (
    .i_pos  (r_ball_x),
    .i_dir  (r_vx),
    .i_step (BALL_V),
    .i_lo   (WALL_X),
    .i_hi   (X_NO_CLAMP),
    .o_next (w_bx_step),
    .o_flip (w_bx_flip)
  );

  pong_axis_step u_step_y (
    .i_pos  (r_ball_y),
    .i_dir  (r_vy),
    .i_step (BALL_V),
    .i_lo   (10'd0),
    .i_hi   (BALL_Y_MAX),
    .o_next (w_by_step),
    .o_flip (w_by_flip)
  );

  pong_axis_step u_step_pad (
    .i_pos  (r_pad_y),
    .i_dir  (w_pad_dir),
    .i_step (w_pad_amt),
    .i_lo   (10'd0),
    .i_hi   (PAD_Y_MAX),
    .o_next (w_pad_step),
    .o_flip ()
  );

  // Hit test on the positions committed in the PAD and BALL cycles
  assign w_ball_front = {1'b0, r_ball_x} + {1'b0, BALL_SIZE};
  assign w_hit = (r_vx == DIR_POS)
              && (w_ball_front >= HIT_X_LO) && (w_ball_front <= HIT_X_HI)
              && (({1'b0, r_ball_y} + {1'b0, BALL_SIZE}) > {1'b0, r_pad_y})
              && ({1'b0, r_ball_y} < ({1'b0, r_pad_y} + {1'b0, PAD_H}));

  // Next-state and datapath updates, one stage of the frame sequence per cycle
  always_comb begin
    w_state_nxt  = r_state;
    w_ball_x_nxt = r_ball_x;
    w_ball_y_nxt = r_ball_y;
    w_pad_y_nxt  = r_pad_y;
    w_vx_nxt     = r_vx;
    w_vy_nxt     = r_vy;
    w_miss       = 1'b0;
    case (r_state)
      IDLE: begin
        if (frame_tick) w_state_nxt = PAD;
      end
      PAD: begin
        w_pad_y_nxt = w_pad_step;
        w_state_nxt = BALL;
      end
      BALL: begin
        w_ball_x_nxt = w_bx_step;
        w_ball_y_nxt = w_by_step;
        if (w_bx_flip) w_vx_nxt = flip_dir(r_vx);
        if (w_by_flip) w_vy_nxt = flip_dir(r_vy);
        w_state_nxt  = HIT;
      end
      HIT: begin
        if (w_hit) begin
          w_ball_x_nxt = PAD_X_L - BALL_SIZE;
          w_vx_nxt     = DIR_NEG;
        end else if (r_ball_x >= BALL_X_MISS) begin
          w_miss       = 1'b1;
          w_ball_x_nxt = BALL_X_RST;
          w_ball_y_nxt = BALL_Y_RST;
          w_vx_nxt     = DIR_NEG;
        end
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and position registers; reset abandons any sequence in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ball_x <= BALL_X_RST;
      r_ball_y <= BALL_Y_RST;
      r_pad_y  <= PAD_Y_RST;
      r_vx     <= DIR_POS;
      r_vy     <= DIR_POS;
    end else begin
      r_state  <= w_state_nxt;
      r_ball_x <= w_ball_x_nxt;
      r_ball_y <= w_ball_y_nxt;
      r_pad_y  <= w_pad_y_nxt;
      r_vx     <= w_vx_nxt;
      r_vy     <= w_vy_nxt;
    end
  end

  assign ball_x = r_ball_x;
  assign ball_y = r_ball_y;
  assign pad_y  = r_pad_y;
  assign busy   = (r_state != IDLE);
  assign miss   = w_miss;

endmodule

// File: tb/tb_pong_frame_ctrl.sv
// Directed bench for pong_frame_ctrl: drives whole frames and checks hand-computed positions.
// Latency: each frame is given a fixed 11-cycle window.
// Backpressure: none.
module tb_pong_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       btn_up;
  logic       btn_down;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] pad_y;
  logic       busy;
  logic       miss;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pong_frame_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .pad_y      (pad_y),
    .busy       (busy),
    .miss       (miss)
  );

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_pos(input string tag, input int x, input int y, input int p);
    check_eq({tag, "_ball_x"}, int'(ball_x), x);
    check_eq({tag, "_ball_y"}, int'(ball_y), y);
    check_eq({tag, "_pad_y"},  int'(pad_y),  p);
  endtask

  // One frame: pulse frame_tick, then watch a fixed window counting busy and miss cycles.
  // With extra set, a second tick is driven while the sequence is in its BALL cycle.
  task automatic do_frame(input logic up, input logic dn, input logic extra,
                          output int busy_n, output int miss_n);
    btn_up     = up;
    btn_down   = dn;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    busy_n = 0;
    miss_n = 0;
    for (int c = 0; c < 10; c++) begin
      if (busy) busy_n++;
      if (miss) miss_n++;
      frame_tick = (extra && c == 1);
      @(negedge clk);
    end
    frame_tick = 1'b0;
    btn_up     = 1'b0;
    btn_down   = 1'b0;
  endtask

  task automatic run_frames(input string tag, input int count, input logic up, input logic dn);
    int b, m, bad;
    bad = 0;
    for (int i = 0; i < count; i++) begin
      do_frame(up, dn, 1'b0, b, m);
      if (b != 3 || m != 0) bad++;
    end
    check_eq({tag, "_bad_frames"}, bad, 0);
  endtask

  initial begin
    int b, m;
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    btn_up     = 1'b0;
    btn_down   = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_pos("rst", 320, 240, 204);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_miss", int'(miss), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Free flight, one frame
    do_frame(1'b0, 1'b0, 1'b0, b, m);
    check_eq("free_busy_cycles", b, 3);
    check_eq("free_miss_cycles", m, 0);
    check_pos("free", 322, 242, 204);

    // Reset while in BALL: paddle already moved, ball not yet
    btn_up     = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    check_eq("midball_busy", int'(busy), 1);
    check_pos("midball", 322, 242, 200);
    #1 rst_n = 1'b0;
    #1;
    check_pos("async_rst", 320, 240, 204);
    check_eq("async_rst_busy", int'(busy), 0);
    @(negedge clk);
    btn_up = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    b = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy) b++;
    end
    check_eq("post_rst_idle_busy", b, 0);
    check_pos("post_rst", 320, 240, 204);

    // Paddle up to the top and clamp there; both buttons hold
    run_frames("up50", 50, 1'b1, 1'b0);
    check_pos("up50", 420, 340, 4);
    run_frames("up51", 1, 1'b1, 1'b0);
    check_pos("up51", 422, 342, 0);
    run_frames("upclamp", 1, 1'b1, 1'b0);
    check_pos("upclamp", 424, 344, 0);
    run_frames("both", 1, 1'b1, 1'b1);
    check_pos("both", 426, 346, 0);

    // Paddle down; ball bounces off the bottom on the way
    run_frames("down64", 64, 1'b0, 1'b1);
    check_pos("bottom", 554, 472, 256);
    run_frames("down101", 37, 1'b0, 1'b1);
    check_pos("down101", 628, 398, 404);
    run_frames("down102", 1, 1'b0, 1'b1);
    check_pos("down102", 630, 396, 408);

    // Ball passes the paddle: miss, plus a dropped tick while busy
    do_frame(1'b0, 1'b1, 1'b1, b, m);
    check_eq("miss_busy_cycles", b, 3);
    check_eq("miss_pulse_cycles", m, 1);
    check_pos("miss", 320, 240, 408);
    run_frames("serve1", 1, 1'b0, 1'b0);
    check_pos("serve1", 318, 238, 408);

    // Top bounce
    run_frames("to_top", 119, 1'b0, 1'b0);
    check_pos("top_reach", 80, 0, 408);
    run_frames("top_flip", 1, 1'b0, 1'b0);
    check_pos("top_flip", 78, 0, 408);
    run_frames("top_after", 1, 1'b0, 1'b0);
    check_pos("top_after", 76, 2, 408);

    // Left wall bounce
    run_frames("to_wall", 22, 1'b0, 1'b0);
    check_pos("wall_reach", 32, 46, 408);
    run_frames("wall_flip", 1, 1'b0, 1'b0);
    check_pos("wall_flip", 32, 48, 408);
    run_frames("wall_after", 1, 1'b0, 1'b0);
    check_pos("wall_after", 34, 50, 408);

    // Line the paddle up and hit the ball at ball_y = pad_y + 10
    run_frames("pad_up20", 20, 1'b1, 1'b0);
    check_pos("pad_up20", 74, 90, 328);
    run_frames("approach", 258, 1'b0, 1'b0);
    check_pos("approach", 590, 340, 328);
    do_frame(1'b0, 1'b0, 1'b0, b, m);
    check_eq("hit_busy_cycles", b, 3);
    check_eq("hit_miss_cycles", m, 0);
    check_pos("hit", 592, 338, 328);
    run_frames("rebound", 1, 1'b0, 1'b0);
    check_pos("rebound", 590, 336, 328);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
